// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - opcodes, FSM states and datapath control encodings shared by mc_controller
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_LBRD, S_LBWR, S_SBWR, S_RTYPEEX,
    S_RTYPEWR, S_BEQEX, S_BNEEX, S_JEX, S_ADDIEX, S_ADDIWR
  } state_t;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_SUB    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_ONE     = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_BROFF   = 2'b11;

  // A single-beat bus still needs a one-bit counter to keep the port widths legal.
  function automatic int beat_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mc_fetch_seq.sv
// rtl/mc_fetch_seq.sv - instruction fetch beat counter with one-hot IR lane enables
module mc_fetch_seq
  import mc_pkg::*;
#(
  parameter int BEATS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch,
  input  logic             memready,
  output logic [BEATS-1:0] irwrite,
  output logic             last
);

  localparam int BW = beat_w(BEATS);

  logic [BW-1:0] beat;
  logic          advance;

  assign advance = fetch & memready;
  assign last    = (beat == BW'(BEATS - 1));
  assign irwrite = advance ? (BEATS'(1) << beat) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat <= '0;
    end else if (advance) begin
      beat <= last ? '0 : beat + BW'(1);
    end
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle mini-MIPS control FSM with parametrised fetch width and memory handshake
module mc_controller
  import mc_pkg::*;
#(
  parameter  int DATA_W  = 8,
  parameter  int INSTR_W = 32,
  localparam int BEATS   = INSTR_W / DATA_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic             zero,
  input  logic             memready,
  output logic             memread,
  output logic             memwrite,
  output logic             alusrca,
  output logic             memtoreg,
  output logic             iord,
  output logic             pcen,
  output logic             regwrite,
  output logic             regdst,
  output logic [1:0]       pcsource,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [BEATS-1:0] irwrite
  ,
  output logic             illegal
);

  state_t state;
  logic   fetch;
  logic   last;

  // Gating fetch with reset keeps irwrite low while reset is held.
  assign fetch = (state == S_FETCH) && reset;

  mc_fetch_seq #(.BEATS(BEATS)) u_fetch (
    .clk      (clk),
    .reset    (reset),
    .fetch    (fetch),
    .memready (memready),
    .irwrite  (irwrite),
    .last     (last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:   if (memready && last) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LB, OP_SB: state <= S_MEMADR;
            OP_RTYPE:     state <= S_RTYPEEX;
            OP_BEQ:       state <= S_BEQEX;
            OP_BNE:       state <= S_BNEEX;
            OP_J:         state <= S_JEX;
            OP_ADDI:      state <= S_ADDIEX;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEMADR:  state <= (op == OP_SB) ? S_SBWR : S_LBRD;
        S_LBRD:    if (memready) state <= S_LBWR;
        S_SBWR:    if (memready) state <= S_FETCH;
        S_RTYPEEX: state <= S_RTYPEWR;
        S_ADDIEX:  state <= S_ADDIWR;
        default:   state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    memread  = 1'b0;
    memwrite = 1'b0;
    alusrca  = 1'b0;
    memtoreg = 1'b0;
    iord     = 1'b0;
    pcen     = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    pcsource = PCSRC_ALU;
    alusrcb  = SRCB_B;
    aluop    = ALUOP_ADD;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_ONE;
        pcen    = memready;
      end
      S_DECODE: begin
        alusrcb = SRCB_BROFF;
        case (op)
          OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_BNE, OP_J, OP_ADDI: illegal = 1'b0;
          default: illegal = 1'b1;
        endcase
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_LBRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_LBWR: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_SBWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsource = PCSRC_ALUOUT;
        pcen     = (state == S_BEQEX) ? zero : ~zero;
      end
      S_JEX: begin
        pcsource = PCSRC_JUMP;
        pcen     = 1'b1;
      end
      S_ADDIWR: regwrite = 1'b1;
      default: ;
    endcase
    // Reset kills every write/request immediately, even mid-instruction.
    if (!reset) begin
      memread  = 1'b0;
      memwrite = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule
